// File: rtl/riscv_inst_encoder.sv
// riscv_inst_encoder: encodes a small RV32I subset into instruction words held in a one-entry output stage.
// Optional feature: define RISCV_ENC_RANGE_CHECK_EN to replace out-of-range immediates with a flagged NOP.
module riscv_inst_encoder #(
   parameter int unsigned            WORD_LENGTH = 32,
   parameter logic [WORD_LENGTH-1:0] BASE_ADDR   = {WORD_LENGTH{1'b0}},
   parameter int unsigned            DEPTH_WORDS = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [3:0]             req_op,
   input  logic [4:0]             req_rd,
   input  logic [4:0]             req_rs1,
   input  logic [4:0]             req_rs2,
   input  logic [WORD_LENGTH-1:0] req_imm,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORD_LENGTH-1:0] out_inst,
   output logic [WORD_LENGTH-1:0] out_addr,
   output logic                   out_err
);

   localparam logic [3:0] OP_ADD     = 4'd0;
   localparam logic [3:0] OP_SUB     = 4'd1;
   localparam logic [3:0] OP_SLL     = 4'd2;
   localparam logic [3:0] OP_SLT     = 4'd3;
   localparam logic [3:0] OP_SLTU    = 4'd4;
   localparam logic [3:0] OP_XOR     = 4'd5;
   localparam logic [3:0] OP_SRL     = 4'd6;
   localparam logic [3:0] OP_SRA     = 4'd7;
   localparam logic [3:0] OP_OR      = 4'd8;
   localparam logic [3:0] OP_AND     = 4'd9;
   localparam logic [3:0] OP_ADDI    = 4'd10;
   localparam logic [3:0] OP_LW      = 4'd11;
   localparam logic [3:0] OP_SW      = 4'd12;
   localparam logic [3:0] OP_JAL     = 4'd13;
   localparam logic [3:0] OP_BEQ     = 4'd14;
   localparam logic [3:0] OP_ILLEGAL = 4'd15;

   localparam logic [31:0]            NOP_INST  = 32'h0000_0013;
   localparam logic [WORD_LENGTH-1:0] LAST_ADDR = BASE_ADDR + WORD_LENGTH'(4 * (DEPTH_WORDS - 1));

   logic                   out_valid_r;
   logic [WORD_LENGTH-1:0] out_inst_r;
   logic [WORD_LENGTH-1:0] out_addr_r;
   logic                   out_err_r;
   logic [WORD_LENGTH-1:0] next_inst_s;
   logic                   next_err_s;
   logic                   range_err_s;
   logic                   accept_s;
   logic                   drain_s;

   function automatic logic [31:0] r_type(input logic [6:0] funct7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] funct3,
                                          input logic [4:0] rd);
      return {funct7, rs2, rs1, funct3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [20:0] imm);
      logic [31:0] w;
      w = 32'h0000_0000;
      case (op)
         OP_ADD:  w = r_type(7'b0000000, rs2, rs1, 3'd0, rd);
         OP_SUB:  w = r_type(7'b0100000, rs2, rs1, 3'd0, rd);
         OP_SLL:  w = r_type(7'b0000000, rs2, rs1, 3'd1, rd);
         OP_SLT:  w = r_type(7'b0000000, rs2, rs1, 3'd2, rd);
         OP_SLTU: w = r_type(7'b0000000, rs2, rs1, 3'd3, rd);
         OP_XOR:  w = r_type(7'b0000000, rs2, rs1, 3'd4, rd);
         OP_SRL:  w = r_type(7'b0000000, rs2, rs1, 3'd5, rd);
         OP_SRA:  w = r_type(7'b0100000, rs2, rs1, 3'd5, rd);
         OP_OR:   w = r_type(7'b0000000, rs2, rs1, 3'd6, rd);
         OP_AND:  w = r_type(7'b0000000, rs2, rs1, 3'd7, rd);
         OP_ADDI: w = {imm[11:0], rs1, 3'd0, rd, 7'b0010011};
         OP_LW:   w = {imm[11:0], rs1, 3'd2, rd, 7'b0000011};
         OP_SW:   w = {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'b0100011};
         // Branch and jump offsets are scrambled into the word; bit 0 is implicit.
         OP_JAL:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
         OP_BEQ:  w = {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], 7'b1100011};
         default: w = NOP_INST;
      endcase
      return w;
   endfunction

`ifdef RISCV_ENC_RANGE_CHECK_EN
   // An immediate fits when every bit above the field's sign bit copies it.
   function automatic logic imm_ok(input logic [3:0] op, input logic [WORD_LENGTH-1:0] imm);
      logic ok;
      case (op)
         OP_ADDI, OP_LW, OP_SW: ok = (&imm[WORD_LENGTH-1:11]) || (~|imm[WORD_LENGTH-1:11]);
         OP_BEQ:  ok = ((&imm[WORD_LENGTH-1:12]) || (~|imm[WORD_LENGTH-1:12])) && !imm[0];
         OP_JAL:  ok = ((&imm[WORD_LENGTH-1:20]) || (~|imm[WORD_LENGTH-1:20])) && !imm[0];
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

   assign range_err_s = !imm_ok(req_op, req_imm);
`else
   logic unused_imm_s;

   assign range_err_s  = 1'b0;
   assign unused_imm_s = ^req_imm[WORD_LENGTH-1:21];
`endif

   assign req_ready = rst_n && !clear && (!out_valid_r || out_ready);
   assign accept_s  = req_valid && req_ready;
   assign drain_s   = out_valid_r && out_ready;

   // Select the encoded word or the flagged NOP substitute.
   always_comb begin
      next_inst_s = {WORD_LENGTH{1'b0}};
      next_err_s  = 1'b0;
      if ((req_op == OP_ILLEGAL) || range_err_s) begin
         next_inst_s = WORD_LENGTH'(NOP_INST);
         next_err_s  = 1'b1;
      end else begin
         next_inst_s = WORD_LENGTH'(encode(req_op, req_rd, req_rs1, req_rs2, req_imm[20:0]));
         next_err_s  = 1'b0;
      end
   end

   // Output holding register: load on accept, empty on drain without refill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_inst_r  <= {WORD_LENGTH{1'b0}};
         out_err_r   <= 1'b0;
      end else if (clear) begin
         out_valid_r <= 1'b0;
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         out_inst_r  <= next_inst_s;
         out_err_r   <= next_err_s;
      end else if (drain_s) begin
         out_valid_r <= 1'b0;
      end
   end

   // Address of the held word; steps on each drain and wraps at the window end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_addr_r <= BASE_ADDR;
      end else if (clear) begin
         out_addr_r <= BASE_ADDR;
      end else if (drain_s) begin
         out_addr_r <= (out_addr_r == LAST_ADDR) ? BASE_ADDR : out_addr_r + WORD_LENGTH'(4);
      end
   end

   assign out_valid = out_valid_r;
   assign out_inst  = out_inst_r;
   assign out_addr  = out_addr_r;
   assign out_err   = out_err_r;

endmodule

// File: tb/tb_riscv_inst_encoder.sv
// Self-checking bench for riscv_inst_encoder: directed vectors plus random traffic against a field-level model.
// Two instances share stimulus: default window and a 4-word window that wraps quickly.
module tb_riscv_inst_encoder;

   logic        clk = 1'b0;
   logic        rst_n, clear, req_valid, out_ready;
   logic [3:0]  req_op;
   logic [4:0]  req_rd, req_rs1, req_rs2;
   logic [31:0] req_imm;
   logic        req_ready, out_valid, out_err;
   logic [31:0] out_inst, out_addr;
   logic        req_ready4, out_valid4, out_err4;
   logic [31:0] out_inst4, out_addr4;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic        m_valid, m_err;
   logic [31:0] m_inst;
   int          m_cnt;

   always #5 clk = ~clk;

   riscv_inst_encoder dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
      .out_err(out_err)
   );

   riscv_inst_encoder #(.WORD_LENGTH(32), .BASE_ADDR(32'h0), .DEPTH_WORDS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid), .req_ready(req_ready4),
      .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
      .out_valid(out_valid4), .out_ready(out_ready), .out_inst(out_inst4), .out_addr(out_addr4),
      .out_err(out_err4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference encoder built from the instruction-set field layout with plain arithmetic.
   function automatic logic [31:0] ref_enc(input int op, input logic [31:0] rd, input logic [31:0] rs1,
                                           input logic [31:0] rs2, input logic [31:0] imm, output bit err);
      logic [31:0] f3, f7;
      int s;
      bit ok;
      s  = $signed(imm);
      ok = 1'b1;
`ifdef RISCV_ENC_RANGE_CHECK_EN
      if (op == 10 || op == 11 || op == 12) ok = (s >= -2048) && (s <= 2047);
      else if (op == 14) ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      else if (op == 13) ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
`endif
      err = (op == 15) || !ok;
      if (err) return 32'h0000_0013;
      if (op <= 9) begin
         f3 = (op < 2) ? 32'd0 : (op < 7) ? 32'(op - 1) : (op == 7) ? 32'd5 : 32'(op - 2);
         f7 = (op == 1 || op == 7) ? 32'd32 : 32'd0;
         return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'd51;
      end
      case (op)
         10: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'd19;
         11: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'd3;
         12: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12)
                    | ((imm & 32'h1F) << 7) | 32'd35;
         13: return (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'd111;
         default: return (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'd1) << 7) | 32'd99;
      endcase
   endfunction

   function automatic logic m_ready();
      return rst_n && !clear && (!m_valid || out_ready);
   endfunction

   task automatic set_req(input int op, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
      req_valid = 1'b1;
      req_op    = 4'(op);
      req_rd    = 5'(rd);
      req_rs1   = 5'(rs1);
      req_rs2   = 5'(rs2);
      req_imm   = imm;
   endtask

   task automatic rand_req();
      int mode;
      logic [31:0] imm;
      mode = $urandom_range(0, 2);
      if (mode == 0) imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      else if (mode == 1) imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      else imm = $urandom;
      set_req($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
   endtask

   // One clock: check the ready output, advance the model over the edge, then check the held word.
   task automatic tick();
      logic acc, drn;
      logic [31:0] w;
      bit e;
      #1;
      chk("req_ready", {31'b0, req_ready}, {31'b0, m_ready()});
      chk("req_ready4", {31'b0, req_ready4}, {31'b0, m_ready()});
      acc = req_valid && m_ready();
      drn = m_valid && out_ready;
      w   = ref_enc(int'(req_op), {27'b0, req_rd}, {27'b0, req_rs1}, {27'b0, req_rs2}, req_imm, e);
      @(posedge clk);
      if (clear) begin
         m_valid = 1'b0;
         m_cnt   = 0;
      end else begin
         if (drn) m_cnt++;
         if (acc) begin
            m_valid = 1'b1;
            m_inst  = w;
            m_err   = e;
         end else if (drn) begin
            m_valid = 1'b0;
         end
      end
      #1;
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("out_valid4", {31'b0, out_valid4}, {31'b0, m_valid});
      if (m_valid) begin
         chk("out_inst", out_inst, m_inst);
         chk("out_err", {31'b0, out_err}, {31'b0, m_err});
         chk("out_inst4", out_inst4, m_inst);
         chk("out_err4", {31'b0, out_err4}, {31'b0, m_err});
      end
      chk("out_addr", out_addr, 32'((m_cnt % 1024) * 4));
      chk("out_addr4", out_addr4, 32'((m_cnt % 4) * 4));
   endtask

   task automatic check_reset();
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_inst", out_inst, 32'd0);
      chk("rst_err", {31'b0, out_err}, 32'd0);
      chk("rst_addr", out_addr, 32'd0);
      chk("rst_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_addr4", out_addr4, 32'd0);
      m_valid = 1'b0;
      m_inst  = 32'd0;
      m_err   = 1'b0;
      m_cnt   = 0;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
      req_valid = 1'b0; req_op = 4'd0; req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check_reset();
      rst_n = 1'b1;
      tick();

      // Reference vectors, drained immediately.
      out_ready = 1'b1;
      set_req(0, 3, 1, 2, 32'd0);
      tick();
      chk("vec_add", out_inst, 32'h002081B3);
      chk("vec_add_addr", out_addr, 32'd0);
      chk("vec_add_err", {31'b0, out_err}, 32'd0);
      set_req(10, 1, 0, 0, 32'hFFFF_FFFF);
      tick();
      chk("vec_addi", out_inst, 32'hFFF00093);
      set_req(12, 0, 1, 2, 32'd8);
      tick();
      chk("vec_sw", out_inst, 32'h0020A423);
      set_req(13, 1, 0, 0, 32'd8);
      tick();
      chk("vec_jal", out_inst, 32'h008000EF);
      set_req(14, 0, 1, 2, 32'hFFFF_FFFC);
      tick();
      chk("vec_beq", out_inst, 32'hFE208EE3);
      set_req(15, 7, 7, 7, 32'd5);
      tick();
      chk("vec_illegal", out_inst, 32'h00000013);
      chk("vec_illegal_err", {31'b0, out_err}, 32'd1);
      set_req(10, 1, 0, 0, 32'd2048);
      tick();
`ifdef RISCV_ENC_RANGE_CHECK_EN
      chk("vec_addi_2048", out_inst, 32'h00000013);
      chk("vec_addi_2048_err", {31'b0, out_err}, 32'd1);
`else
      chk("vec_addi_2048", out_inst, 32'h80000093);
      chk("vec_addi_2048_err", {31'b0, out_err}, 32'd0);
`endif

      // Stall for three cycles with a request waiting, then stream back to back.
      out_ready = 1'b0;
      set_req(5, 4, 5, 6, 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_req(8, 9, 10, 11, 32'd0);
         tick();
         chk("stall_ready", {31'b0, req_ready}, 32'd0);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_req();
         tick();
         chk("b2b_valid", {31'b0, out_valid}, 32'd1);
      end

      // Clear with a word held and a request presented.
      out_ready = 1'b0;
      clear = 1'b1;
      tick();
      chk("clear_valid", {31'b0, out_valid}, 32'd0);
      chk("clear_addr", out_addr, 32'd0);
      clear = 1'b0;
      tick();

      // Reset in the middle of a stalled transfer.
      tick();
      rst_n = 1'b0;
      #2;
      check_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_reset_ready", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      tick();

      // Random traffic with occasional clears.
      for (int i = 0; i < 600; i++) begin
         rand_req();
         req_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         clear     = ($urandom_range(0, 39) == 0);
         tick();
      end
      clear = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_inst_encoder.md
RISCV_INST_ENCODER -- requirements
Module: riscv_inst_encoder

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 32, meaning instruction and address width.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0, meaning byte address of the first emitted word.
REQ-003 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning address window size in words, a power of two.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning reset; reset is asynchronous and active-low.
REQ-006 The block SHALL have port clear, input, 1, meaning synchronous flush of the output stage and the address counter.
REQ-007 The block SHALL have port req_valid, input, 1, meaning an encode request is present.
REQ-008 The block SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-009 The block SHALL have port req_op, input, 4, meaning operation code: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 ADDI, 11 LW, 12 SW, 13 JAL, 14 BEQ, 15 illegal.
REQ-010 The block SHALL have ports req_rd, req_rs1 and req_rs2, input, 5 each, meaning register indices.
REQ-011 The block SHALL have port req_imm, input, WORD_LENGTH, meaning a signed byte-offset immediate.
REQ-012 The block SHALL have port out_valid, output, 1, meaning an encoded word is held.
REQ-013 The block SHALL have port out_ready, input, 1, meaning the sink takes the word.
REQ-014 The block SHALL have port out_inst, output, WORD_LENGTH, meaning the RV32I instruction word.
REQ-015 The block SHALL have port out_addr, output, WORD_LENGTH, meaning the byte address of out_inst.
REQ-016 The block SHALL have port out_err, output, 1, meaning the word was substituted with NOP because of an error.

Function
REQ-017 The request handshake SHALL complete on req_valid&&req_ready, with req_ready = !out_valid || out_ready.
REQ-018 out_valid, out_inst and out_err SHALL be registered, with latency 1 cycle from the accepted request to out_valid=1.
REQ-019 While out_valid&&!out_ready, out_inst, out_addr and out_err SHALL hold stable.
REQ-020 When a drain and an accept happen in the same cycle, the new word SHALL load with out_valid staying 1 and no bubble.
REQ-021 R-type ops SHALL use opcode 0110011 and funct3 ADD/SUB 0, SLL 1, SLT 2, SLTU 3, XOR 4, SRL/SRA 5, OR 6, AND 7; funct7 SHALL be 0100000 for SUB/SRA and 0 otherwise.
REQ-022 ADDI SHALL encode as opcode 0010011 with funct3 0, and LW as opcode 0000011 with funct3 2, both in I-format imm[11:0].
REQ-023 SW SHALL encode as opcode 0100011 with funct3 2 in S-format, and BEQ as opcode 1100011 with funct3 0 in B-format using imm[12:1].
REQ-024 JAL SHALL encode as opcode 1101111 in J-format using imm[20:1], with no register fields other than rd.
REQ-025 Fields unused by a format SHALL be zero.
REQ-026 For req_op=15, out_inst SHALL be 32'h00000013 and out_err SHALL be 1.
REQ-027 out_addr SHALL start at BASE_ADDR and advance by 4 on each out_valid&&out_ready.
REQ-028 out_addr SHALL wrap from BASE_ADDR+4*(DEPTH_WORDS-1) back to BASE_ADDR.
REQ-029 On clear, out_valid SHALL go to 0 and out_addr to BASE_ADDR next cycle, and any request presented in the same cycle SHALL be dropped, with req_ready forced to 0.

Reset
REQ-030 While rst_n=0, outputs SHALL be out_valid=0, out_inst=0, out_err=0, out_addr=BASE_ADDR and req_ready=0.
REQ-031 Reset asserted mid-transfer SHALL discard the held word, and the first cycle after release SHALL show req_ready=1.

Configuration
REQ-032 With macro RISCV_ENC_RANGE_CHECK_EN defined, an out-of-range immediate SHALL produce out_inst=32'h00000013 and out_err=1.
REQ-033 The ranges checked SHALL be: I/S -2048..2047; B -4096..4094 and even; J -1048576..1048574 and even.
REQ-034 Without RISCV_ENC_RANGE_CHECK_EN, immediates SHALL be truncated to the field bits with no error, and out_err SHALL flag only op 15.

Verification
REQ-035 ADD rd=3 rs1=1 rs2=2 -> out_inst 32'h002081B3, out_addr 0, out_err 0.
REQ-036 ADDI rd=1 rs1=0 imm=-1 -> 32'hFFF00093; SW rs1=1 rs2=2 imm=8 -> 32'h0020A423.
REQ-037 JAL rd=1 imm=8 -> 32'h008000EF; BEQ rs1=1 rs2=2 imm=-4 -> 32'hFE208EE3.
REQ-038 out_ready=0 for 3 cycles after out_valid -> out_inst stable and req_ready=0; then back-to-back stream with out_ready=1 -> one word per cycle.
REQ-039 DEPTH_WORDS=4 with 5 drained words -> out_addr 0,4,8,12,0.
REQ-040 ADDI rd=1 imm=2048 -> with macro 32'h00000013 and out_err=1; without macro 32'h80000093 and out_err=0.
